// File: rtl/uart_loader_if.sv
// Memory write bus between uart_loader and the bus arbiter.
//   mem_req   : write request, held until granted
//   mem_gnt   : arbiter grant; write completes in the cycle mem_req & mem_gnt
//   mem_addr  : word address, stable while mem_req is high
//   mem_wdata : write data, stable while mem_req is high
interface uart_loader_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (output mem_req, output mem_addr, output mem_wdata, input mem_gnt);
    modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_gnt);
endinterface

// File: rtl/uart_loader.sv
// Framed program loader: turns UART bytes into 16-bit memory writes.
// Frame: HEADER, ADDR_HI, ADDR_LO, COUNT, COUNT x (WORD_HI, WORD_LO), CSUM.
// Ports:
//   clk_25M, rst_n          : clock, async active-low reset
//   rx_data, rx_ready       : byte and data-ready level from uart_rx (slow domain)
//   bus (master)            : mem_req/mem_gnt/mem_addr/mem_wdata write handshake
//   cpu_halt, busy          : CPU stall while loading, frame in progress
//   done                    : 1-cycle pulse on a frame with good checksum
//   err_csum/overrun/timeout: sticky error flags, cleared by the next HEADER
module uart_loader #(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
    input  logic          clk_25M,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    uart_loader_if.master bus,
    output logic          cpu_halt,
    output logic          busy,
    output logic          done,
    output logic          err_csum,
    output logic          err_overrun,
    output logic          err_timeout
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W = 9;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA_HI, S_DATA_LO, S_CSUM
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sync;
    logic               r_prev;
    logic               r_strobe;
    logic [15:0]        r_addr;
    logic [7:0]         r_hi;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_csum;
    logic               r_pend;
    logic               r_done_wait;
    logic [15:0]        r_mem_addr;
    logic [15:0]        r_mem_wdata;
    logic               r_done;
    logic               r_err_csum;
    logic               r_err_overrun;
    logic               r_err_timeout;
    logic [TMO_W-1:0]   r_tmo;

    logic               w_grant;
    logic               w_pend_eff;
    logic [7:0]         w_csum_nxt;
    logic               w_tmo_hit;

    // A grant in this cycle frees the write slot before a new word is checked.
    assign w_grant    = r_pend & bus.mem_gnt;
    assign w_pend_eff = r_pend & ~bus.mem_gnt;
    assign w_csum_nxt = r_csum + rx_data;
    assign w_tmo_hit  = (r_state != S_IDLE) && !r_strobe &&
                        (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sync        <= 2'b00;
            r_prev        <= 1'b0;
            r_strobe      <= 1'b0;
            r_addr        <= 16'h0000;
            r_hi          <= 8'h00;
            r_cnt         <= '0;
            r_csum        <= 8'h00;
            r_pend        <= 1'b0;
            r_done_wait   <= 1'b0;
            r_mem_addr    <= 16'h0000;
            r_mem_wdata   <= 16'h0000;
            r_done        <= 1'b0;
            r_err_csum    <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tmo         <= '0;
        end else begin
            // Two-flop synchroniser plus registered rising-edge detect.
            r_sync   <= {r_sync[0], rx_ready};
            r_prev   <= r_sync[1];
            r_strobe <= r_sync[1] & ~r_prev;
            r_done   <= 1'b0;

            if (w_grant) begin
                r_pend <= 1'b0;
                if (r_done_wait) begin
                    r_done      <= 1'b1;
                    r_done_wait <= 1'b0;
                end
            end

            // Inter-byte gap counter, only meaningful mid-frame.
            if (r_strobe || r_state == S_IDLE) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (w_tmo_hit) begin
                r_err_timeout <= 1'b1;
                r_state       <= S_IDLE;
            end else if (r_strobe) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == HEADER) begin
                            r_state       <= S_ADDR_HI;
                            r_csum        <= 8'h00;
                            r_err_csum    <= 1'b0;
                            r_err_overrun <= 1'b0;
                            r_err_timeout <= 1'b0;
                        end
                    end
                    S_ADDR_HI: begin
                        r_addr[15:8] <= rx_data;
                        r_csum       <= w_csum_nxt;
                        r_state      <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        r_addr[7:0] <= rx_data;
                        r_csum      <= w_csum_nxt;
                        r_state     <= S_COUNT;
                    end
                    S_COUNT: begin
                        // A count byte of zero encodes 256 words.
                        r_cnt   <= (rx_data == 8'h00) ? CNT_W'(256) : CNT_W'(rx_data);
                        r_csum  <= w_csum_nxt;
                        r_state <= S_DATA_HI;
                    end
                    S_DATA_HI: begin
                        r_hi    <= rx_data;
                        r_csum  <= w_csum_nxt;
                        r_state <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        r_csum <= w_csum_nxt;
                        if (w_pend_eff) begin
                            r_err_overrun <= 1'b1;
                        end else begin
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= {r_hi, rx_data};
                            r_pend      <= 1'b1;
                        end
                        // Address advances even for a dropped word.
                        r_addr  <= r_addr + 16'd1;
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_state <= (r_cnt == CNT_W'(1)) ? S_CSUM : S_DATA_HI;
                    end
                    S_CSUM: begin
                        r_csum  <= w_csum_nxt;
                        r_state <= S_IDLE;
                        if (w_csum_nxt != 8'h00) begin
                            r_err_csum <= 1'b1;
                        end else if (w_pend_eff) begin
                            r_done_wait <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.mem_req   = r_pend;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign busy          = (r_state != S_IDLE);
    assign cpu_halt      = (r_state != S_IDLE) | r_pend;
    assign done          = r_done;
    assign err_csum      = r_err_csum;
    assign err_overrun   = r_err_overrun;
    assign err_timeout   = r_err_timeout;
endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: expected writes are queued as frames are sent
// and checked when the DUT's write handshake completes.
module tb_uart_loader;
    localparam int unsigned TMO = 200;

    logic       clk_25M;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       cpu_halt, busy, done, err_csum, err_overrun, err_timeout;

    uart_loader_if bus ();

    uart_loader #(.HEADER(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_25M    (clk_25M),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .bus        (bus),
        .cpu_halt   (cpu_halt),
        .busy       (busy),
        .done       (done),
        .err_csum   (err_csum),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    initial clk_25M = 1'b0;
    always #20 clk_25M = ~clk_25M;

    int          n_chk = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic        halt_at_done = 1'b0;
    logic        gnt_en = 1'b1;
    logic [31:0] sb_q[$];
    logic [7:0]  fr[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Arbiter model: grant one cycle after a request is seen.
    initial begin
        bus.mem_gnt = 1'b0;
        forever begin
            @(posedge clk_25M);
            #1;
            if (gnt_en && bus.mem_req && !bus.mem_gnt) bus.mem_gnt = 1'b1;
            else bus.mem_gnt = 1'b0;
        end
    end

    // Write monitor and done counter.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk_25M);
            if (bus.mem_req && bus.mem_gnt) begin
                chk("sb_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    chk("sb_write", {bus.mem_addr, bus.mem_wdata}, exp);
                end
            end
            if (done) begin
                done_cnt++;
                halt_at_done = cpu_halt;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_25M); #1;
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (6) @(posedge clk_25M);
        #1 rx_ready = 1'b0;
        repeat (6) @(posedge clk_25M);
    endtask

    task automatic send_frame();
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic wait_halt_drop(input int max_cyc);
        for (int i = 0; i < max_cyc && cpu_halt; i++) @(negedge clk_25M);
    endtask

    initial begin
        int d0;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk_25M);
        @(negedge clk_25M);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halt", 32'(cpu_halt), 0);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_errs", {29'd0, err_csum, err_overrun, err_timeout}, 0);
        #1 rst_n = 1'b1;

        // Basic frame.
        d0 = done_cnt;
        sb_q.push_back({16'h0100, 16'h1234});
        sb_q.push_back({16'h0101, 16'hABCD});
        fr = {8'hA5, 8'h01, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h3F};
        send_frame();
        wait_halt_drop(50);
        chk("t1_done", 32'(done_cnt - d0), 1);
        chk("t1_halt_at_done", 32'(halt_at_done), 0);
        chk("t1_errs", {29'd0, err_csum, err_overrun, err_timeout}, 0);
        chk("t1_sb_empty", 32'(sb_q.size()), 0);
        chk("t1_busy", 32'(busy), 0);

        // Bad checksum: writes still happen, no done.
        d0 = done_cnt;
        sb_q.push_back({16'h0100, 16'h1234});
        sb_q.push_back({16'h0101, 16'hABCD});
        fr[8] = 8'h40;
        send_frame();
        wait_halt_drop(50);
        chk("t2_err_csum", 32'(err_csum), 1);
        chk("t2_done", 32'(done_cnt - d0), 0);
        chk("t2_halt", 32'(cpu_halt), 0);
        chk("t2_sb_empty", 32'(sb_q.size()), 0);

        // Overrun with grant withheld.
        d0 = done_cnt;
        gnt_en = 1'b0;
        sb_q.push_back({16'h0200, 16'h1111});
        fr = {8'hA5, 8'h02, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h96};
        send_frame();
        chk("t3_overrun", 32'(err_overrun), 1);
        chk("t3_req_held", 32'(bus.mem_req), 1);
        chk("t3_wdata_held", 32'(bus.mem_wdata), 32'h1111);
        chk("t3_addr_held", 32'(bus.mem_addr), 32'h0200);
        chk("t3_halt_pend", 32'(cpu_halt), 1);
        gnt_en = 1'b1;
        wait_halt_drop(50);
        repeat (2) @(negedge clk_25M);
        chk("t3_done", 32'(done_cnt - d0), 1);
        chk("t3_sb_empty", 32'(sb_q.size()), 0);
        chk("t3_req_drop", 32'(bus.mem_req), 0);

        // Timeout after partial frame.
        d0 = done_cnt;
        fr = {8'hA5, 8'h01, 8'h00};
        send_frame();
        chk("t4_busy_mid", 32'(busy), 1);
        repeat (TMO + 100) @(posedge clk_25M);
        @(negedge clk_25M);
        chk("t4_err_tmo", 32'(err_timeout), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_halt", 32'(cpu_halt), 0);
        chk("t4_req", 32'(bus.mem_req), 0);
        chk("t4_done", 32'(done_cnt - d0), 0);

        // Address wrap.
        d0 = done_cnt;
        sb_q.push_back({16'hFFFF, 16'h1111});
        sb_q.push_back({16'h0000, 16'h2222});
        fr = {8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h9A};
        send_frame();
        wait_halt_drop(50);
        chk("t5_done", 32'(done_cnt - d0), 1);
        chk("t5_errs", {29'd0, err_csum, err_overrun, err_timeout}, 0);
        chk("t5_sb_empty", 32'(sb_q.size()), 0);

        // Reset mid-frame with a write pending.
        gnt_en = 1'b0;
        fr = {8'hA5, 8'h03, 8'h00, 8'h02, 8'h55, 8'h66};
        send_frame();
        chk("t6_req_pre", 32'(bus.mem_req), 1);
        @(negedge clk_25M);
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(bus.mem_req), 0);
        chk("t6_halt", 32'(cpu_halt), 0);
        chk("t6_busy", 32'(busy), 0);
        repeat (2) @(posedge clk_25M);
        #1 rst_n = 1'b1;
        gnt_en = 1'b1;
        d0 = done_cnt;
        sb_q.push_back({16'h0100, 16'h1234});
        sb_q.push_back({16'h0101, 16'hABCD});
        fr = {8'hA5, 8'h01, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h3F};
        send_frame();
        wait_halt_drop(50);
        chk("t6_done", 32'(done_cnt - d0), 1);
        chk("t6_errs", {29'd0, err_csum, err_overrun, err_timeout}, 0);
        chk("t6_sb_empty", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
